// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter_if : requester/transmitter bundle for uart_tx_arbiter     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ack;
  logic [DATA_WIDTH-1:0]         tx_datain;
  logic                          tx_send;
  logic                          tx_ready;
  logic                          busy;
  logic [IDW-1:0]                active_id;
  logic                          timeout_err;

  modport slave (
    input  req, req_data, tx_ready,
    output req_ack, tx_datain, tx_send, busy, active_id, timeout_err
  );

  modport master (
    output req, req_data, tx_ready,
    input  req_ack, tx_datain, tx_send, busy, active_id, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin sharing of one uart_tx among NUM_REQ        |
// | byte producers, one byte per grant. Rev 1.0                               |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int             IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]     C_CNT_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [IDW-1:0] C_LAST_IDX = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACC  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [IDW-1:0]        ptr_q;
  logic [IDW-1:0]        active_id_q;
  logic [7:0]            cnt_q;
  logic [DATA_WIDTH-1:0] tx_datain_q;
  logic                  tx_send_q;
  logic                  busy_q;
  logic                  timeout_err_q;
  logic [NUM_REQ-1:0]    req_ack_q;

  logic [IDW-1:0]        win_d;
  logic                  win_vld_d;
  logic [IDW-1:0]        ptr_d;
  logic [DATA_WIDTH-1:0] win_data_d;

  // Lowest requester overall is the fallback; lowest at/after ptr overrides it.
  always_comb begin
    win_d     = '0;
    win_vld_d = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_vld_d = 1'b1;
        win_d     = IDW'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (IDW'(i) >= ptr_q)) begin
        win_d = IDW'(i);
      end
    end
  end

  always_comb begin
    win_data_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_d == IDW'(i)) begin
        win_data_d = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ptr_d = (win_d == C_LAST_IDX) ? '0 : win_d + IDW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      active_id_q   <= '0;
      cnt_q         <= '0;
      tx_datain_q   <= '0;
      tx_send_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      req_ack_q     <= '0;
    end else begin
      tx_send_q     <= 1'b0;
      req_ack_q     <= '0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.tx_ready && win_vld_d) begin
            tx_datain_q <= win_data_d;
            active_id_q <= win_d;
            ptr_q       <= ptr_d;
            tx_send_q   <= 1'b1;
            req_ack_q   <= NUM_REQ'(1) << win_d;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_ACC;
        end
        S_WAIT_ACC: begin
          if (!bus.tx_ready) begin
            state_q <= S_WAIT_DONE;
          end else if (cnt_q >= C_CNT_LAST) begin
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_WAIT_DONE: begin
          if (bus.tx_ready) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ack     = req_ack_q;
  assign bus.tx_datain   = tx_datain_q;
  assign bus.tx_send     = tx_send_q;
  assign bus.busy        = busy_q;
  assign bus.active_id   = active_id_q;
  assign bus.timeout_err = timeout_err_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_arbiter : directed vectors and corner sequences for the arbiter|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ACK_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        rdy;
    logic        send;
    logic [3:0]  ack;
    logic [7:0]  din;
    logic        busy;
    logic [1:0]  id;
  } vec_t;

  vec_t vt[18];

  int n_cmp = 0;
  int n_err = 0;
  int t = 0;
  int send_t = 0;
  int prev_send_t = 0;
  int to_t = 0;
  int to_cnt = 0;
  int mcnt = 0;
  logic to_busy = 1'b1;
  logic auto_en = 1'b0;
  logic stuck = 1'b0;
  logic [7:0] sent_q[$];
  logic [1:0] ack_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock; in auto mode also acts as the uart_tx model and the requesters.
  task automatic step();
    logic [3:0] exp_ack;
    @(posedge clk); #1;
    t++;
    if (auto_en) begin
      if (bus.tx_send) begin
        sent_q.push_back(bus.tx_datain);
        if (prev_send_t > 0) begin
          n_cmp++;
          if (t - prev_send_t < 4) begin
            n_err++;
            $display("FAIL send_spacing: got %0d cycles expected >= 4", t - prev_send_t);
          end
        end
        prev_send_t = t;
        send_t = t;
        if (!stuck) mcnt = 3;
      end else if (mcnt > 0) begin
        mcnt--;
      end
      bus.tx_ready = (mcnt == 0);
      if (bus.tx_send || (bus.req_ack != 4'b0)) begin
        exp_ack = 4'b0001 << bus.active_id;
        chk("ack_with_send", {27'b0, bus.tx_send, bus.req_ack}, {27'b0, 1'b1, exp_ack});
        ack_q.push_back(bus.active_id);
        bus.req = bus.req & ~bus.req_ack;
      end
      if (bus.timeout_err) begin
        to_cnt++;
        to_t = t;
        to_busy = bus.busy;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    prev_send_t = 0;
  endtask

  initial begin
    vt[0]  = '{4'b0100, 32'h00A50000, 1'b1, 1'b1, 4'b0100, 8'hA5, 1'b1, 2'd2};
    vt[1]  = '{4'b0000, 32'h00A50000, 1'b1, 1'b0, 4'b0000, 8'hA5, 1'b1, 2'd2};
    vt[2]  = '{4'b0000, 32'h00A50000, 1'b0, 1'b0, 4'b0000, 8'hA5, 1'b1, 2'd2};
    vt[3]  = '{4'b0000, 32'h00A50000, 1'b0, 1'b0, 4'b0000, 8'hA5, 1'b1, 2'd2};
    vt[4]  = '{4'b0000, 32'h00A50000, 1'b1, 1'b0, 4'b0000, 8'hA5, 1'b0, 2'd2};
    vt[5]  = '{4'b1001, 32'h33000030, 1'b1, 1'b1, 4'b1000, 8'h33, 1'b1, 2'd3};
    vt[6]  = '{4'b0001, 32'h33000030, 1'b1, 1'b0, 4'b0000, 8'h33, 1'b1, 2'd3};
    vt[7]  = '{4'b0001, 32'h33000030, 1'b0, 1'b0, 4'b0000, 8'h33, 1'b1, 2'd3};
    vt[8]  = '{4'b0001, 32'h33000030, 1'b1, 1'b0, 4'b0000, 8'h33, 1'b0, 2'd3};
    vt[9]  = '{4'b0001, 32'h33000030, 1'b1, 1'b1, 4'b0001, 8'h30, 1'b1, 2'd0};
    vt[10] = '{4'b0000, 32'h33000030, 1'b1, 1'b0, 4'b0000, 8'h30, 1'b1, 2'd0};
    vt[11] = '{4'b0000, 32'h33000030, 1'b0, 1'b0, 4'b0000, 8'h30, 1'b1, 2'd0};
    vt[12] = '{4'b0000, 32'h33000030, 1'b1, 1'b0, 4'b0000, 8'h30, 1'b0, 2'd0};
    vt[13] = '{4'b0010, 32'h00007700, 1'b0, 1'b0, 4'b0000, 8'h30, 1'b0, 2'd0};
    vt[14] = '{4'b0010, 32'h00007700, 1'b1, 1'b1, 4'b0010, 8'h77, 1'b1, 2'd1};
    vt[15] = '{4'b0000, 32'h00007700, 1'b1, 1'b0, 4'b0000, 8'h77, 1'b1, 2'd1};
    vt[16] = '{4'b0000, 32'h00007700, 1'b0, 1'b0, 4'b0000, 8'h77, 1'b1, 2'd1};
    vt[17] = '{4'b0000, 32'h00007700, 1'b1, 1'b0, 4'b0000, 8'h77, 1'b0, 2'd1};

    rst          = 1'b1;
    bus.req      = 4'b0;
    bus.req_data = 32'h0;
    bus.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_send", {31'b0, bus.tx_send}, 32'd0);
    chk("rst_ack", {28'b0, bus.req_ack}, 32'd0);
    chk("rst_din", {24'b0, bus.tx_datain}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_id", {30'b0, bus.active_id}, 32'd0);
    chk("rst_to", {31'b0, bus.timeout_err}, 32'd0);
    rst = 1'b0;

    // Directed cycle-by-cycle vectors, tx_ready driven by hand.
    for (int i = 0; i < 18; i++) begin
      bus.req      = vt[i].req;
      bus.req_data = vt[i].data;
      bus.tx_ready = vt[i].rdy;
      step();
      chk($sformatf("v%0d_send", i), {31'b0, bus.tx_send}, {31'b0, vt[i].send});
      chk($sformatf("v%0d_ack", i), {28'b0, bus.req_ack}, {28'b0, vt[i].ack});
      chk($sformatf("v%0d_din", i), {24'b0, bus.tx_datain}, {24'b0, vt[i].din});
      chk($sformatf("v%0d_busy", i), {31'b0, bus.busy}, {31'b0, vt[i].busy});
      chk($sformatf("v%0d_id", i), {30'b0, bus.active_id}, {30'b0, vt[i].id});
      chk($sformatf("v%0d_to", i), {31'b0, bus.timeout_err}, 32'd0);
    end

    // Asynchronous reset while in WAIT_DONE, then ptr restarts at 0.
    bus.req = 4'b0100; bus.req_data = 32'h00C30000; bus.tx_ready = 1'b1;
    step();
    chk("wd_grant", {31'b0, bus.tx_send}, 32'd1);
    bus.req = 4'b0000;
    step();
    bus.tx_ready = 1'b0;
    step();
    chk("wd_busy", {31'b0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_send", {31'b0, bus.tx_send}, 32'd0);
    chk("arst_ack", {28'b0, bus.req_ack}, 32'd0);
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_id", {30'b0, bus.active_id}, 32'd0);
    chk("arst_din", {24'b0, bus.tx_datain}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req = 4'b1010; bus.req_data = 32'hB300B100; bus.tx_ready = 1'b1;
    step();
    chk("post_rst_ack", {28'b0, bus.req_ack}, 32'h2);
    chk("post_rst_din", {24'b0, bus.tx_datain}, 32'hB1);
    bus.req = 4'b1000;
    step();
    bus.tx_ready = 1'b0;
    step();
    bus.tx_ready = 1'b1;
    step();
    step();
    chk("post_rst_ack3", {28'b0, bus.req_ack}, 32'h8);
    chk("post_rst_din3", {24'b0, bus.tx_datain}, 32'hB3);
    bus.req = 4'b0000;
    step();
    bus.tx_ready = 1'b0;
    step();
    bus.tx_ready = 1'b1;
    step();

    // All four requesters from reset, served in order, then wrap to 0.
    pulse_reset();
    auto_en = 1'b1; stuck = 1'b0; mcnt = 0; bus.tx_ready = 1'b1;
    sent_q.delete(); ack_q.delete();
    bus.req = 4'b1111; bus.req_data = 32'h13121110;
    for (int k = 0; k < 80 && sent_q.size() < 4; k++) step();
    chk("rr_count", sent_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_byte%0d", i), (i < sent_q.size()) ? {24'b0, sent_q[i]} : 32'hFFFFFFFF,
          32'h10 + i);
      chk($sformatf("rr_ack%0d", i), (i < ack_q.size()) ? {30'b0, ack_q[i]} : 32'hFFFFFFFF, i);
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 40 && ack_q.size() < 5; k++) step();
    chk("rr_wrap", (ack_q.size() >= 5) ? {30'b0, ack_q[4]} : 32'hFFFFFFFF, 32'd0);
    bus.req = 4'b0000;
    repeat (10) step();

    // tx never accepts: timeout after 16 ready cycles, then pending req served.
    pulse_reset();
    stuck = 1'b1; mcnt = 0; bus.tx_ready = 1'b1; to_cnt = 0; to_t = 0; send_t = 0;
    sent_q.delete(); ack_q.delete();
    bus.req = 4'b0011; bus.req_data = 32'h00002221;
    for (int k = 0; k < 100 && to_cnt < 1; k++) step();
    chk("to_count", to_cnt, 32'd1);
    chk("to_latency", to_t - send_t, 32'd17);
    chk("to_busy", {31'b0, to_busy}, 32'd0);
    stuck = 1'b0;
    for (int k = 0; k < 100 && sent_q.size() < 2; k++) step();
    repeat (10) step();
    chk("to_next_count", sent_q.size(), 32'd2);
    chk("to_byte0", (sent_q.size() > 0) ? {24'b0, sent_q[0]} : 32'hFFFFFFFF, 32'h21);
    chk("to_byte1", (sent_q.size() > 1) ? {24'b0, sent_q[1]} : 32'hFFFFFFFF, 32'h22);
    chk("to_once", to_cnt, 32'd1);

    // Request withdrawn one cycle before tx_ready rises: nothing happens.
    auto_en = 1'b0;
    bus.tx_ready = 1'b0; bus.req = 4'b0001; bus.req_data = 32'h000000EE;
    step();
    bus.req = 4'b0000;
    step();
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("wd%0d_send", k), {31'b0, bus.tx_send}, 32'd0);
      chk($sformatf("wd%0d_ack", k), {28'b0, bus.req_ack}, 32'd0);
      chk($sformatf("wd%0d_busy", k), {31'b0, bus.busy}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
